// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

    localparam int TIMER_WIDTH = 8;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and a single-cycle
// terminal-count pulse, intended as a programmable timeout or tick source.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int               WIDTH       = TIMER_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(8'hFF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy,
    output timer_state_t     dbg_state
);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= RESET_VALUE;
            reload_q <= RESET_VALUE;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // tc_d defaults low so the pulse can never stretch past one cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? RUN : DONE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (enable) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (count_q == WIDTH'(1)) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                            state_d = auto_reload ? RUN : DONE;
                        end else if (auto_reload) begin
                            // Zero is held one enabled cycle before reloading,
                            // giving a period of reload + 1.
                            count_d = reload_q;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign count     = count_q;
    assign zero      = (count_q == '0);
    assign tc_pulse  = tc_q;
    assign busy      = (state_q == RUN);
    assign dbg_state = state_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable 8-bit down-counter. It is the counterpart to the team's free-running up-counter: the up-counter measures elapsed cycles, this block expires after a programmed number of cycles. It has a one-shot mode and an auto-reload mode, and emits a single-cycle terminal-count pulse. It sits beside the existing counter and is used as a programmable timeout/tick source for control logic.

Parameters:
WIDTH, 8, width of count, load_value and the internal reload register
RESET_VALUE, 8'hFF, value loaded into count and reload register on reset (WIDTH bits)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
load  input  1  load strobe; samples load_value on the rising edge
load_value  input  WIDTH  start/reload value
enable  input  1  count-enable; one decrement per enabled cycle in RUN
auto_reload  input  1  1 = reload on expiry, 0 = one-shot
count  output  WIDTH  current counter value (registered)
zero  output  1  count == 0, decoded from the count register, no extra latency
tc_pulse  output  1  registered, high for exactly one cycle when count goes 1 -> 0
busy  output  1  state == RUN

Behaviour:
- Reset (synchronous, highest priority over load/enable):
  - state = IDLE; count = RESET_VALUE; reload_reg = RESET_VALUE; tc_pulse = 0.
  - Outputs after reset: count = 8'hFF, zero = 0, tc_pulse = 0, busy = 0.
- States: IDLE, RUN, DONE.
- IDLE: count holds; enable ignored. Leaves only via load.
- load (any state, priority over enable):
  - count <= load_value; reload_reg <= load_value; tc_pulse <= 0.
  - Next state = RUN if load_value != 0, else DONE (no tc_pulse for a zero load).
- RUN, enable = 0: count holds; tc_pulse <= 0.
- RUN, enable = 1:
  - count > 1: count <= count - 1.
  - count == 1: count <= 0; tc_pulse <= 1; next state = auto_reload ? RUN : DONE.
  - count == 0 (reachable only via auto-reload): if auto_reload, count <= reload_reg and stay in RUN; else go to DONE. No tc_pulse in either case.
- Auto-reload period = reload_reg + 1 enabled cycles, with one tc_pulse per period.
- DONE: count = 0, zero = 1; enable ignored. Leaves only via load.
- tc_pulse is cleared on every cycle where it is not set by the count == 1 decrement, so it is never asserted on consecutive cycles.
- Arithmetic: unsigned modulo-2^WIDTH. Underflow is impossible by construction (0 never decrements).
- Simultaneous events:
  - reset beats load.
  - load beats enable; a load on the expiry cycle suppresses that tc_pulse.
  - auto_reload is sampled only on the expiry or reload cycle; changing it mid-count has no other effect.
- Reset mid-count: the next cycle shows reset values; any in-progress pulse is dropped.
- busy falls in the same cycle count reaches 0 in one-shot mode.

Decomposition:
- Package timer_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;
  - localparam TIMER_WIDTH = 8.
- No sub-module: one always_ff for state, count, reload_reg and tc_pulse, plus continuous assigns for zero and busy.
- Estimated size ~150 lines.

Test Plan:
1. Reset: reset = 1 for 3 cycles -> count = 0xFF, zero = 0, busy = 0, tc_pulse = 0. enable = 1 with no load -> count stays 0xFF.
2. One-shot: load 0x03, auto_reload = 0, enable = 1 -> count 03, 02, 01, 00; tc_pulse high only in the 00 cycle; busy = 0 from then on; count held at 0x00 for 10 further cycles.
3. Auto-reload: load 0x02, auto_reload = 1, enable = 1 for 9 cycles -> count 02, 01, 00, 02, 01, 00, 02...; tc_pulse every 3rd cycle; busy stays 1.
4. Enable gating: load 0x04, toggle enable 1, 0, 1, 0 -> count decrements only on enabled cycles; 4 enabled cycles to tc_pulse.
5. Collisions:
   - load 0x05 on the cycle count == 1 with enable = 1 -> count = 0x05, no tc_pulse.
   - load 0x00 -> DONE, zero = 1, tc_pulse = 0.
6. Reset mid-count: load 0x10, enable 4 cycles (count 0x0C), assert reset -> next cycle count = 0xFF, state IDLE, busy = 0.
